// File: rtl/tick_pkg.sv
// Shared constants and helpers for the tick divider bank.
package tick_pkg;

  localparam int unsigned CNT_W_DEF        = 32;
  localparam int unsigned MAX_NUM_CH       = 8;
  localparam int unsigned DIV_10KHZ_TOGGLE = 5_000;
  localparam int unsigned DIV_1HZ_TOGGLE   = 50_000_000;

  // Index width that never collapses to zero bits for a single channel.
  function automatic int unsigned idx_w(int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int unsigned CH_IDX_W = idx_w(MAX_NUM_CH);

endpackage

// File: rtl/tick_channel.sv
// One divider channel: counter, active/pending divisor, registered strobe and toggle.
module tick_channel
  import tick_pkg::*;
#(
  parameter int unsigned     CntW    = CNT_W_DEF,
  parameter logic [CntW-1:0] DivInit = '0
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            en_i,
  input  logic            clr_i,
  input  logic            adv_i,
  input  logic            wr_i,
  input  logic [CntW-1:0] wr_data_i,
  output logic            strobe_o,
  output logic            toggle_o
);

  logic [CntW-1:0] cnt_q, cnt_d;
  logic [CntW-1:0] act_q, act_d;
  logic [CntW-1:0] pend_q, pend_d;
  logic            strobe_q, strobe_d;
  logic            toggle_q, toggle_d;
  logic            halted;
  logic            wrap;

  always_comb begin
    halted   = (act_q == '0);
    wrap     = en_i && adv_i && !halted && (cnt_q == act_q - CntW'(1));
    cnt_d    = cnt_q;
    act_d    = act_q;
    pend_d   = wr_i ? wr_data_i : pend_q;
    strobe_d = 1'b0;
    toggle_d = toggle_q;
    // Loading from pend_d makes a same-cycle write bypass straight into the divisor.
    if (clr_i) begin
      cnt_d    = '0;
      toggle_d = 1'b0;
      act_d    = pend_d;
    end else if (wrap) begin
      cnt_d    = '0;
      strobe_d = 1'b1;
      toggle_d = ~toggle_q;
      act_d    = pend_d;
    end else begin
      if (en_i && adv_i && !halted) begin
        cnt_d = cnt_q + CntW'(1);
      end
      if (halted && wr_i && (wr_data_i != '0)) begin
        act_d = wr_data_i;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q    <= '0;
      act_q    <= DivInit;
      pend_q   <= DivInit;
      strobe_q <= 1'b0;
      toggle_q <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      act_q    <= act_d;
      pend_q   <= pend_d;
      strobe_q <= strobe_d;
      toggle_q <= toggle_d;
    end
  end

  assign strobe_o = strobe_q;
  assign toggle_o = toggle_q;

endmodule

// File: rtl/tick_divider_bank.sv
// Multi-channel programmable tick generator with runtime-loadable divisors.
// Define TICK_CASCADE_EN to clock channel k>0 from the strobe of channel k-1.
module tick_divider_bank
  import tick_pkg::*;
#(
  parameter int unsigned              NUM_CH   = 2,
  parameter int unsigned              CNT_W    = CNT_W_DEF,
  parameter logic [NUM_CH*CNT_W-1:0]  DIV_INIT = {32'(DIV_1HZ_TOGGLE), 32'(DIV_10KHZ_TOGGLE)}
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_CH-1:0]         ch_en,
  input  logic [NUM_CH-1:0]         ch_clr,
  input  logic                      div_wr,
  input  logic [idx_w(NUM_CH)-1:0]  div_sel,
  input  logic [CNT_W-1:0]          div_data,
  output logic [NUM_CH-1:0]         strobe,
  output logic [NUM_CH-1:0]         toggle
);

  logic [NUM_CH-1:0] wr_hit;
  logic [NUM_CH-1:0] adv;

  for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
    // Out-of-range selects simply match no channel.
    assign wr_hit[k] = div_wr && (CH_IDX_W'(div_sel) == CH_IDX_W'(k));

`ifdef TICK_CASCADE_EN
    if (k == 0) begin : g_adv_clk
      assign adv[k] = 1'b1;
    end else begin : g_adv_prev
      assign adv[k] = strobe[k-1];
    end
`else
    assign adv[k] = 1'b1;
`endif

    tick_channel #(
      .CntW    (CNT_W),
      .DivInit (DIV_INIT[k*CNT_W +: CNT_W])
    ) u_ch (
      .clk_i     (clk),
      .rst_ni    (rst_n),
      .en_i      (ch_en[k]),
      .clr_i     (ch_clr[k]),
      .adv_i     (adv[k]),
      .wr_i      (wr_hit[k]),
      .wr_data_i (div_data),
      .strobe_o  (strobe[k]),
      .toggle_o  (toggle[k])
    );
  end

endmodule

// File: doc/tick_divider_bank.md
Name: tick_divider_bank

Overview:
Multi-channel programmable tick generator. It is the parametrised successor to the fixed 1 Hz / 10 kHz divider. Each channel divides clk by a runtime-loadable divisor and produces two outputs: a one-cycle strobe and a 50%-duty toggle. It sits beside the stopwatch datapath and feeds the display scan, debounce and timekeeping logic from one block.

Parameters:
NUM_CH, 2, number of independent channels (1..8).
CNT_W, 32, counter and divisor width in bits.
DIV_INIT, {32'd50_000_000, 32'd5_000}, flattened NUM_CH*CNT_W reset divisors; channel 0 occupies the LSBs.

Ports:
clk  in  1  system clock (100 MHz on board).
rst_n  in  1  asynchronous active-low reset.
ch_en  in  NUM_CH  per-channel run enable.
ch_clr  in  NUM_CH  per-channel synchronous clear.
div_wr  in  1  divisor write strobe.
div_sel  in  $clog2(NUM_CH) (min 1)  channel addressed by div_wr.
div_data  in  CNT_W  new divisor value.
strobe  out  NUM_CH  one-cycle pulse per period.
toggle  out  NUM_CH  square wave, period 2*divisor clocks.

Behaviour:
- Reset (rst_n low, asynchronous):
  - counters = 0; strobe = 0; toggle = 0.
  - active_div[k] and pending_div[k] = DIV_INIT slice k.
- Counting: when ch_en[k]=1 and active_div[k]>=1:
  - cnt increments each clk.
  - When cnt == active_div-1: cnt <= 0, strobe[k] <= 1 for exactly one cycle (registered), toggle[k] inverts.
  - Strobe period = active_div clocks.
  - Example: divisor 5000 gives a 20 kHz strobe and a 10 kHz toggle, identical to the legacy 10 kHz output.
- Divisor 1: strobe held high continuously; toggle inverts every clock.
- Divisor 0: channel halted. cnt held at 0, strobe = 0, toggle frozen.
- ch_en=0: cnt, toggle and active_div hold; strobe = 0. On re-enable, counting resumes from the held cnt.
- ch_clr[k]=1: cnt <= 0, strobe <= 0, toggle <= 0, regardless of ch_en. Clear takes priority over the wrap in the same cycle. Clear does not alter the divisors.
- Divisor write:
  - div_wr with div_sel=k loads pending_div[k] on the next edge.
  - active_div[k] <= pending_div[k] only at a wrap (cnt == active_div-1) or on ch_clr. This guarantees no truncated or runt periods.
  - div_wr on the same cycle as the wrap or clear: div_data goes directly into active_div (bypass), so the next period already uses it.
  - While halted (active_div == 0): a write with a nonzero value is also bypassed into active_div immediately.
  - div_sel >= NUM_CH: write ignored.
- Latency: strobe asserts in the cycle after cnt reaches active_div-1. There is no combinational path from inputs to outputs.
- Width: counter compare is done at CNT_W bits unsigned. Counter wrap is only via the compare, never by overflow.

Optional Feature:
Macro TICK_CASCADE_EN.
- Defined: channel k>0 advances only on cycles where strobe[k-1] is high, instead of every clk. This gives cascaded division (e.g. ch0 = 1 kHz, ch1 divisor 1000 gives 1 Hz) with CNT_W-bit counters. Channel 0 always counts clk.
- Undefined: all channels count clk independently, and the cascade logic is absent.

Decomposition:
- Shared package tick_pkg holds:
  - CNT_W default, NUM_CH maximum.
  - CH_IDX_W constant (clog2 helper).
  - Legacy divisor constants DIV_10KHZ_TOGGLE = 5000 and DIV_1HZ_TOGGLE = 50_000_000.
- One sub-module, tick_channel, holds one counter, active/pending divisor, strobe and toggle, plus an advance input (tied to 1, or to the previous strobe under TICK_CASCADE_EN).
- The top level handles write decode and generate-instantiates NUM_CH channels.

Test Plan:
1. Reset with defaults, ch_en=2'b11, run 20_000 clks -> ch0 strobe every 5000 clks, toggle period 10_000; ch1 no strobe before clk 50_000_000.
2. ch0 divisor 10, write 4 at cnt=3 -> current period completes at 10 clks, following periods are 4 clks, no runt pulse.
3. Write 7 on the exact wrap cycle -> the very next period is 7 clks (bypass).
4. ch_clr asserted on the wrap cycle -> no strobe that cycle, cnt=0, toggle=0, the next strobe exactly divisor clks later.
5. Write divisor 0 -> strobe stays 0 and toggle frozen; write 3 -> strobe resumes every 3 clks; divisor 1 -> strobe continuously high.
6. Assert rst_n low mid-period, asynchronously between edges -> outputs drop immediately and divisors revert to DIV_INIT. With TICK_CASCADE_EN, ch0=4 and ch1=3 -> ch1 strobes every 12 clks.
